// File: rtl/md_iteration_sequencer_pkg.sv
// Shared types and helpers for the MD iteration sequencer.
// Holds the sequencer state encoding and drain-counter width rule.
package md_iteration_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_FORCE  = 3'd2,
        S_FLUSH  = 3'd3,
        S_MU     = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    // Counter must be able to hold the value n itself.
    function automatic int drain_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DRAIN_CNT_W = drain_cnt_w(64);

endpackage

// File: rtl/md_iteration_sequencer_ref_wb_drain_tracker.sv
// Ref-writeback tracker: collects per-PE writeback pulses, then waits
// for the ring to drain. Ports: clk, rst (async low), active (FORCE),
// ref_wb_issued, goto_next_ref -> all_ref_wb_issued, interconnect_empty.
module ref_wb_drain_tracker
    import md_iteration_sequencer_pkg::*;
#(
    parameter int NUM_CELLS    = 64,
    parameter int DRAIN_CYCLES = NUM_CELLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 active,
    input  logic [NUM_CELLS-1:0] ref_wb_issued,
    input  logic                 goto_next_ref,
    output logic                 all_ref_wb_issued,
    output logic                 interconnect_empty
);

    localparam int DW = drain_cnt_w(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

    logic [NUM_CELLS-1:0] r_flags;
    logic [NUM_CELLS-1:0] flags_n;
    logic [DW-1:0]        drain_cnt;
    logic                 drain_end;
    logic                 clear;

    assign flags_n   = r_flags | ref_wb_issued;
    assign drain_end = drain_cnt == DRAIN_MAX;
    // Pulses landing on a clearing cycle are intentionally lost.
    assign clear     = !active | goto_next_ref |
                       (all_ref_wb_issued & drain_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags           <= '0;
            all_ref_wb_issued <= 1'b0;
            drain_cnt         <= '0;
        end else if (clear) begin
            r_flags           <= '0;
            all_ref_wb_issued <= 1'b0;
            drain_cnt         <= '0;
        end else if (!all_ref_wb_issued) begin
            r_flags           <= flags_n;
            all_ref_wb_issued <= &flags_n;
            drain_cnt         <= '0;
        end else begin
            drain_cnt         <= drain_cnt + DW'(1);
        end
    end

    assign interconnect_empty = all_ref_wb_issued & drain_end;

endmodule

// File: rtl/md_iteration_sequencer.sv
// Run controller: sequences N timesteps of force evaluation + motion
// update. Ports: start/abort/cfg_num_iter control, broadcast/cache/MU
// status in; iter_start, motion_update_start, run_done pulses,
// busy, iter_count, per-phase cycle counters and timeout_err out.
module md_iteration_sequencer
    import md_iteration_sequencer_pkg::*;
#(
    parameter int NUM_CELLS    = 64,
    parameter int ITER_WIDTH   = 16,
    parameter int CYC_WIDTH    = 32,
    parameter int DRAIN_CYCLES = NUM_CELLS,
    parameter int WDOG_CYCLES  = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] cfg_num_iter,
    input  logic [NUM_CELLS-1:0]  ref_wb_issued,
    input  logic                  goto_next_ref,
    input  logic                  all_reading_done,
    input  logic                  all_filter_buffer_empty,
    input  logic [NUM_CELLS-1:0]  force_wr_enable,
    input  logic                  force_cache_input_buffer_empty,
    input  logic                  mu_done,
    output logic                  iter_start,
    output logic                  all_ref_wb_issued,
    output logic                  all_force_wr_issued,
    output logic                  motion_update_start,
    output logic                  busy,
    output logic                  run_done,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic [CYC_WIDTH-1:0]  force_cycles,
    output logic [CYC_WIDTH-1:0]  mu_cycles,
    output logic                  timeout_err
);

    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    seq_state_t            state;
    seq_state_t            state_n;
    logic [ITER_WIDTH-1:0] cfg_q;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic [WW-1:0]         wdog_cnt;
    logic                  interconnect_empty;
    logic                  force_exit;
    logic                  wdog_exp;
    logic                  last_iter;
    logic                  accept;
    logic                  timeout_hit;
    logic                  in_force;

    ref_wb_drain_tracker #(
        .NUM_CELLS    (NUM_CELLS),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_tracker (
        .clk                (clk),
        .rst                (rst),
        .active             (state == S_FORCE),
        .ref_wb_issued      (ref_wb_issued),
        .goto_next_ref      (goto_next_ref),
        .all_ref_wb_issued  (all_ref_wb_issued),
        .interconnect_empty (interconnect_empty)
    );

    assign all_force_wr_issued = (force_wr_enable == '0) &
                                 force_cache_input_buffer_empty &
                                 all_filter_buffer_empty &
                                 interconnect_empty;

    assign force_exit = all_reading_done & all_force_wr_issued;
    assign wdog_exp   = wdog_cnt == WDOG_LAST;
    assign iter_inc   = iter_count + ITER_WIDTH'(1);
    assign last_iter  = iter_inc == cfg_q;
    assign accept     = (state == S_IDLE) & start & !abort;
    assign in_force   = (state == S_FORCE) | (state == S_FLUSH);
    // Watchdog only fires when the phase would otherwise stay put.
    assign timeout_hit = !abort & wdog_exp &
                         (((state == S_FORCE) & !force_exit) |
                          ((state == S_MU) & !mu_done));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start)
                        state_n = (cfg_num_iter == '0) ? S_DONE : S_LAUNCH;
                end
                S_LAUNCH: state_n = S_FORCE;
                S_FORCE: begin
                    if (force_exit)       state_n = S_FLUSH;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_FLUSH: state_n = S_MU;
                S_MU: begin
                    if (mu_done)          state_n = S_NEXT;
                    else if (timeout_hit) state_n = S_IDLE;
                end
                S_NEXT: state_n = last_iter ? S_DONE : S_LAUNCH;
                S_DONE: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        iter_start          = 1'b0;
        motion_update_start = 1'b0;
        run_done            = 1'b0;
        busy = (state != S_IDLE) & (state != S_DONE);
        if (!abort) begin
            unique case (state)
                S_LAUNCH: iter_start          = 1'b1;
                S_FLUSH:  motion_update_start = 1'b1;
                S_DONE:   run_done            = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q        <= '0;
            iter_count   <= '0;
            force_cycles <= '0;
            mu_cycles    <= '0;
            timeout_err  <= 1'b0;
            wdog_cnt     <= '0;
        end else begin
            if (state_n != state)  wdog_cnt <= '0;
            else if (!wdog_exp)    wdog_cnt <= wdog_cnt + WW'(1);

            if (accept) begin
                cfg_q        <= cfg_num_iter;
                iter_count   <= '0;
                force_cycles <= '0;
                mu_cycles    <= '0;
                timeout_err  <= 1'b0;
            end else if (!abort) begin
                if (state == S_NEXT)
                    iter_count <= iter_inc;
                if (in_force && force_cycles != '1)
                    force_cycles <= force_cycles + CYC_WIDTH'(1);
                if (state == S_MU && mu_cycles != '1)
                    mu_cycles <= mu_cycles + CYC_WIDTH'(1);
                if (timeout_hit)
                    timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_iteration_sequencer.sv
// Self-checking bench for md_iteration_sequencer (4 cells, drain 4,
// watchdog 64) with randomized timing and an arithmetic timing model.
module tb_md_iteration_sequencer;

    localparam int NC = 4;
    localparam int IW = 16;
    localparam int CW = 32;
    localparam int DR = 4;
    localparam int WD = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] cfg_num_iter = '0;
    logic [NC-1:0] ref_wb_issued = '0;
    logic          goto_next_ref = 1'b0;
    logic          all_reading_done = 1'b1;
    logic          all_filter_buffer_empty = 1'b1;
    logic [NC-1:0] force_wr_enable = '0;
    logic          force_cache_input_buffer_empty = 1'b1;
    logic          mu_done = 1'b0;
    logic          iter_start;
    logic          all_ref_wb_issued;
    logic          all_force_wr_issued;
    logic          motion_update_start;
    logic          busy;
    logic          run_done;
    logic [IW-1:0] iter_count;
    logic [CW-1:0] force_cycles;
    logic [CW-1:0] mu_cycles;
    logic          timeout_err;

    md_iteration_sequencer #(
        .NUM_CELLS(NC), .ITER_WIDTH(IW), .CYC_WIDTH(CW),
        .DRAIN_CYCLES(DR), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_num_iter(cfg_num_iter), .ref_wb_issued(ref_wb_issued),
        .goto_next_ref(goto_next_ref),
        .all_reading_done(all_reading_done),
        .all_filter_buffer_empty(all_filter_buffer_empty),
        .force_wr_enable(force_wr_enable),
        .force_cache_input_buffer_empty(force_cache_input_buffer_empty),
        .mu_done(mu_done), .iter_start(iter_start),
        .all_ref_wb_issued(all_ref_wb_issued),
        .all_force_wr_issued(all_force_wr_issued),
        .motion_update_start(motion_update_start), .busy(busy),
        .run_done(run_done), .iter_count(iter_count),
        .force_cycles(force_cycles), .mu_cycles(mu_cycles),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int n_is = 0;
    int n_ms = 0;
    int n_rd = 0;

    always begin
        @(negedge clk);
        #2;
        if (iter_start === 1'b1)          n_is++;
        if (motion_update_start === 1'b1) n_ms++;
        if (run_done === 1'b1)            n_rd++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run(input int cfg);
        tick();
        cfg_num_iter = IW'(cfg);
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        #1;
    endtask

    task automatic wait_launch(output bit ok);
        int n = 0;
        while (iter_start !== 1'b1 && n < 40) begin
            tick(); #1; n++;
        end
        ok = (iter_start === 1'b1);
    endtask

    task automatic finish_mu(input int d);
        for (int i = 1; i <= d; i++) begin
            tick(); mu_done = (i == d); #1;
        end
        tick(); mu_done = 1'b0; #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick(); #1; n++;
        end
        tick(); #1;
    endtask

    task automatic do_abort();
        tick(); abort = 1'b1; #1;
        tick(); abort = 1'b0; #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({iter_start, motion_update_start, run_done, busy} !== 4'b0)
            $display("FAIL reset_pulses: got %b want 0000",
                     {iter_start, motion_update_start, run_done, busy});
        else passed++;
        checks++;
        if ({all_ref_wb_issued, all_force_wr_issued, timeout_err} !== 3'b0)
            $display("FAIL reset_flags: got %b want 000",
                     {all_ref_wb_issued, all_force_wr_issued, timeout_err});
        else passed++;
        checks++;
        if (iter_count !== '0 || force_cycles !== '0 || mu_cycles !== '0)
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0",
                     iter_count, force_cycles, mu_cycles);
        else passed++;
    endtask

    task automatic test_zero_iter();
        int is0 = n_is;
        start_run(0);
        checks++;
        if (run_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL zero_done: run_done=%b busy=%b want 1 0",
                     run_done, busy);
        else passed++;
        checks++;
        if (timeout_err !== 1'b0 || iter_count !== '0 || mu_cycles !== '0)
            $display("FAIL zero_clear: terr=%b iter=%0d mu=%0d want 0",
                     timeout_err, iter_count, mu_cycles);
        else passed++;
        tick(); #1;
        checks++;
        if (run_done !== 1'b0 || n_is != is0)
            $display("FAIL zero_after: run_done=%b iter_starts=%0d want 0 0",
                     run_done, n_is - is0);
        else passed++;
    endtask

    task automatic test_run(input int cfg, input int mud);
        int arr[NC];
        int k, fc, d, c, got, ef, em, is0, ms0, rd0;
        bit ok;
        is0 = n_is; ms0 = n_ms; rd0 = n_rd;
        ef = 0; em = 0;
        start_run(cfg);
        for (int it = 0; it < cfg; it++) begin
            wait_launch(ok);
            checks++;
            if (!ok) $display("FAIL run_launch: no iter_start it=%0d", it);
            else passed++;
            k = 0;
            for (int b = 0; b < NC; b++) begin
                arr[b] = int'($urandom_range(1, 6));
                if (arr[b] > k) k = arr[b];
            end
            fc = k + 1 + DR;
            got = 0;
            c = 0;
            while (got == 0 && c < 60) begin
                c++;
                tick();
                for (int b = 0; b < NC; b++)
                    ref_wb_issued[b] = (arr[b] == c);
                #1;
                if (motion_update_start === 1'b1) got = c;
            end
            ref_wb_issued = '0;
            checks++;
            if (got != fc + 1)
                $display("FAIL run_flush_cycle: got %0d want %0d", got, fc + 1);
            else passed++;
            ef += fc + 1;
            d = (mud != 0) ? mud : int'($urandom_range(1, 12));
            em += d;
            finish_mu(d);
        end
        wait_idle();
        checks++;
        if (n_is - is0 != cfg || n_ms - ms0 != cfg || n_rd - rd0 != 1)
            $display("FAIL run_pulses: is=%0d ms=%0d rd=%0d want %0d %0d 1",
                     n_is - is0, n_ms - ms0, n_rd - rd0, cfg, cfg);
        else passed++;
        checks++;
        if (iter_count !== IW'(cfg))
            $display("FAIL run_iter_count: got %0d want %0d", iter_count, cfg);
        else passed++;
        checks++;
        if (force_cycles !== CW'(ef) || mu_cycles !== CW'(em))
            $display("FAIL run_cycles: got %0d/%0d want %0d/%0d",
                     force_cycles, mu_cycles, ef, em);
        else passed++;
    endtask

    task automatic test_ref_tracking();
        int arr[NC] = '{5, 7, 9, 9};
        int far = 0, ffw = 0, fms = 0;
        bit ok;
        start_run(1);
        wait_launch(ok);
        for (int c = 1; c <= 16; c++) begin
            tick();
            for (int b = 0; b < NC; b++)
                ref_wb_issued[b] = (arr[b] == c);
            #1;
            if (all_ref_wb_issued === 1'b1 && far == 0) far = c;
            if (all_force_wr_issued === 1'b1 && ffw == 0) ffw = c;
            if (motion_update_start === 1'b1 && fms == 0) fms = c;
        end
        ref_wb_issued = '0;
        checks++;
        if (far != 10 || ffw != 14 || fms != 15)
            $display("FAIL ref_track: ar=%0d fw=%0d ms=%0d want 10 14 15",
                     far, ffw, fms);
        else passed++;
        finish_mu(3);
        wait_idle();
        checks++;
        if (force_cycles !== CW'(15) || mu_cycles !== CW'(4) ||
            iter_count !== IW'(1))
            $display("FAIL ref_track_cnt: got %0d/%0d/%0d want 15/4/1",
                     force_cycles, mu_cycles, iter_count);
        else passed++;
    endtask

    task automatic test_goto_next_ref();
        int bad = 0, ms0;
        logic ar3, ar5;
        bit ok;
        ar3 = 1'b0; ar5 = 1'b1;
        start_run(1);
        wait_launch(ok);
        ms0 = n_ms;
        for (int c = 1; c <= 12; c++) begin
            tick();
            ref_wb_issued = (c == 1) ? '1 : '0;
            goto_next_ref = (c == 4);
            mu_done = (c == 6);
            start = (c == 7);
            #1;
            if (all_force_wr_issued === 1'b1) bad++;
            if (c == 3) ar3 = all_ref_wb_issued;
            if (c == 5) ar5 = all_ref_wb_issued;
        end
        ref_wb_issued = '0; goto_next_ref = 1'b0;
        mu_done = 1'b0; start = 1'b0;
        checks++;
        if (ar3 !== 1'b1 || ar5 !== 1'b0)
            $display("FAIL goto_clear: ar3=%b ar5=%b want 1 0", ar3, ar5);
        else passed++;
        checks++;
        if (bad != 0 || busy !== 1'b1 || n_ms != ms0)
            $display("FAIL goto_hold: fw=%0d busy=%b ms=%0d want 0 1 0",
                     bad, busy, n_ms - ms0);
        else passed++;
        do_abort();
        checks++;
        if (busy !== 1'b0 || iter_count !== '0)
            $display("FAIL goto_abort: busy=%b iter=%0d want 0 0",
                     busy, iter_count);
        else passed++;
    endtask

    task automatic test_force_gating();
        int bad_fw = 0, bad_ms = 0, rd0;
        logic ar2;
        bit ok;
        ar2 = 1'b0;
        force_wr_enable = 4'b0010;
        start_run(1);
        wait_launch(ok);
        for (int c = 1; c <= 20; c++) begin
            tick();
            ref_wb_issued = (c == 1) ? '1 : '0;
            #1;
            if (all_force_wr_issued === 1'b1) bad_fw++;
            if (motion_update_start === 1'b1) bad_ms++;
            if (c == 2) ar2 = all_ref_wb_issued;
        end
        ref_wb_issued = '0;
        checks++;
        if (ar2 !== 1'b1 || bad_fw != 0 || bad_ms != 0)
            $display("FAIL gate_force: ar=%b fw=%0d ms=%0d want 1 0 0",
                     ar2, bad_fw, bad_ms);
        else passed++;
        rd0 = n_rd;
        do_abort();
        force_wr_enable = '0;
        tick(); #1;
        checks++;
        if (busy !== 1'b0 || n_rd != rd0 || force_cycles !== CW'(20))
            $display("FAIL gate_abort: busy=%b rd=%0d fc=%0d want 0 0 20",
                     busy, n_rd - rd0, force_cycles);
        else passed++;
    endtask

    task automatic test_watchdog();
        int n = 0, c = 0, rd0;
        bit ok, fin;
        rd0 = n_rd;
        start_run(1);
        wait_launch(ok);
        while (motion_update_start !== 1'b1 && c < 30) begin
            tick();
            ref_wb_issued = (c == 0) ? '1 : '0;
            #1;
            c++;
        end
        ref_wb_issued = '0;
        fin = 1'b0;
        while (!fin && n < 100) begin
            tick(); #1;
            if (busy === 1'b1) n++;
            else fin = 1'b1;
        end
        tick(); #1;
        checks++;
        if (n != WD || timeout_err !== 1'b1)
            $display("FAIL wdog_expiry: mu_cycles=%0d terr=%b want %0d 1",
                     n, timeout_err, WD);
        else passed++;
        checks++;
        if (n_rd != rd0 || busy !== 1'b0 || mu_cycles !== CW'(WD))
            $display("FAIL wdog_state: rd=%0d busy=%b mu=%0d want 0 0 %0d",
                     n_rd - rd0, busy, mu_cycles, WD);
        else passed++;
    endtask

    task automatic test_async_reset();
        int is0;
        logic ar3;
        bit ok;
        ar3 = 1'b0;
        start_run(2);
        wait_launch(ok);
        for (int c = 1; c <= 3; c++) begin
            tick();
            ref_wb_issued = (c == 1) ? '1 : '0;
            #1;
            if (c == 3) ar3 = all_ref_wb_issued;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ar3 !== 1'b1 || all_ref_wb_issued !== 1'b0 || busy !== 1'b0)
            $display("FAIL arst_flags: pre=%b ar=%b busy=%b want 1 0 0",
                     ar3, all_ref_wb_issued, busy);
        else passed++;
        checks++;
        if (force_cycles !== '0 || iter_start !== 1'b0)
            $display("FAIL arst_counters: fc=%0d is=%b want 0 0",
                     force_cycles, iter_start);
        else passed++;
        tick();
        rst = 1'b1;
        is0 = n_is;
        repeat (6) tick();
        #1;
        checks++;
        if (busy !== 1'b0 || n_is != is0)
            $display("FAIL arst_resume: busy=%b is=%0d want 0 0",
                     busy, n_is - is0);
        else passed++;
    endtask

    initial begin
        repeat (3) tick();
        #1;
        test_reset();
        tick();
        rst = 1'b1;
        tick();
        test_zero_iter();
        test_run(3, 10);
        test_ref_tracking();
        test_goto_next_ref();
        test_force_gating();
        test_watchdog();
        test_zero_iter();
        for (int r = 0; r < 3; r++)
            test_run(int'($urandom_range(1, 4)), 0);
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/md_iteration_sequencer.md
Name: md_iteration_sequencer

Overview:
- Top-level run controller for the range-limited MD core. It sequences N timesteps of force evaluation followed by motion update.
- It replaces the ad-hoc start/MU_done loop and the inline ref-writeback drain tracking.
- It issues iter_start to broadcast_controller and motion_update_start to motion_update_control, and exposes per-phase cycle counters plus a watchdog error.

Parameters:
- NUM_CELLS, 64, number of PEs/cells; width of per-cell vectors.
- ITER_WIDTH, 16, width of iteration count/config.
- CYC_WIDTH, 32, width of per-phase cycle counters.
- DRAIN_CYCLES, NUM_CELLS, cycles to wait after the last ref writeback for the ring to empty.
- WDOG_CYCLES, 1048576, max cycles in any phase before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  run request, sampled only in IDLE.
- abort  in  1  forces return to IDLE from any state.
- cfg_num_iter  in  ITER_WIDTH  iterations to run, latched on accepted start; 0 = complete immediately.
- ref_wb_issued  in  NUM_CELLS  per-PE pulse: ref-particle force writeback issued.
- goto_next_ref  in  1  from broadcast_controller: clears ref tracking.
- all_reading_done  in  1  from broadcast_controller.
- all_filter_buffer_empty  in  1  from broadcast_controller.
- force_wr_enable  in  NUM_CELLS  ring data_valid into force caches.
- force_cache_input_buffer_empty  in  1  from all_force_caches.
- mu_done  in  1  pulse from motion_update_control.
- iter_start  out  1  one-cycle pulse to broadcast_controller.
- all_ref_wb_issued  out  1  all PEs issued ref writeback, ring draining.
- all_force_wr_issued  out  1  force phase fully retired.
- motion_update_start  out  1  one-cycle pulse.
- busy  out  1  high outside IDLE/DONE.
- run_done  out  1  one-cycle pulse at run completion.
- iter_count  out  ITER_WIDTH  completed iterations.
- force_cycles  out  CYC_WIDTH  cycles spent in FORCE+FLUSH, accumulated over the run.
- mu_cycles  out  CYC_WIDTH  cycles spent in MU, accumulated over the run.
- timeout_err  out  1  sticky, set on watchdog expiry.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; ref flags, drain counter, watchdog cleared.
- States: IDLE, LAUNCH, FORCE, FLUSH, MU, NEXT, DONE.
- IDLE: on start, latch cfg_num_iter, clear iter_count, force_cycles, mu_cycles and timeout_err. Go to DONE if cfg=0, else LAUNCH.
- LAUNCH: iter_start=1 for exactly one cycle, then FORCE.
- FORCE: wait until all_reading_done & all_force_wr_issued, then FLUSH.
- FLUSH: motion_update_start=1 for one cycle, then MU.
- MU: on mu_done go to NEXT. A mu_done seen in any other state is ignored.
- NEXT: iter_count+1. If the new count equals the latched cfg, go to DONE; else LAUNCH.
- DONE: run_done=1 for one cycle, then IDLE. iter_count and the cycle counters hold their values until the next start.
- Ref tracking, active in FORCE only; flags are held cleared in other states:
  - Sub-state TRACK: r_flags |= ref_wb_issued each cycle. When &r_flags, set all_ref_wb_issued and drain_cnt=0.
  - Sub-state DRAIN: drain_cnt++ until DRAIN_CYCLES. goto_next_ref or reaching DRAIN_CYCLES clears the flags, all_ref_wb_issued and drain_cnt (back to TRACK).
  - An ref_wb_issued pulse arriving in the same cycle as the clear is dropped.
- interconnect_empty = all_ref_wb_issued & (drain_cnt==DRAIN_CYCLES).
- all_force_wr_issued (combinational) = (force_wr_enable==0) & force_cache_input_buffer_empty & all_filter_buffer_empty & interconnect_empty.
- Counters: force_cycles increments every cycle in FORCE and FLUSH; mu_cycles every cycle in MU. Both saturate at all-ones.
- Watchdog: per-state counter reset on every state change. Expiry in FORCE or MU sets timeout_err and goes to IDLE without a run_done pulse.
- abort: synchronous, highest priority. Next state is IDLE; no pulses that cycle; counters hold.
- start while busy is ignored.

Decomposition:
- md_pkg additions: seq_state_t enum (7 states, 3 bits) and localparam DRAIN_CNT_W = $clog2(DRAIN_CYCLES+1).
- One sub-module: ref_wb_drain_tracker, containing the flags, drain counter, all_ref_wb_issued and interconnect_empty.

Test Plan:
- cfg_num_iter=3, all handshakes immediate, mu_done 10 cycles after motion_update_start -> exactly 3 iter_start and 3 motion_update_start pulses, iter_count=3, one run_done.
- cfg=0 with start -> run_done two cycles after start, no iter_start, iter_count=0.
- NUM_CELLS=4; ref_wb_issued bits arrive on cycles 5,7,9,9 -> all_ref_wb_issued rises cycle 10; interconnect_empty 4 cycles later; all_force_wr_issued only if force_wr_enable=0 and buffers empty.
- goto_next_ref at drain_cnt=2 -> flags cleared next cycle; interconnect_empty never asserted in that window.
- mu_done withheld, WDOG_CYCLES=64 -> timeout_err=1 at cycle 64 of MU, state IDLE, no run_done.
- rst deasserted→asserted (low) mid-FORCE -> outputs 0 immediately without a clock edge; after release, start is required to resume.
